// File: rtl/renas_write_buffer.sv
// Write buffer between the data cache and main memory: queues word write-backs,
// coalesces repeated writes, forwards buffered data to lookups and drains one entry at a time.
module renas_write_buffer #(
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_OFFSET = 2,
    parameter int WB_DEPTH    = 4
) (
    input  logic                                cache_clk,
    input  logic                                rst,
    input  logic                                push_req,
    input  logic [DATA_LENGTH-1:0]              push_addr,
    input  logic [DATA_LENGTH-1:0]              push_data,
    output logic                                push_ack,
    output logic                                wb_full_o,
    output logic                                wb_empty_o,
    output logic [$clog2(WB_DEPTH):0]           wb_count,
    input  logic [DATA_LENGTH-1:0]              lookup_addr,
    output logic                                lookup_hit,
    output logic [DATA_LENGTH-1:0]              lookup_data,
    output logic [2*DATA_LENGTH-BYTE_OFFSET-1:0] wb_data,
    output logic                                wb_req,
    input  logic                                wb_ack,
    input  logic                                full_flag
);
    localparam int AW = DATA_LENGTH - BYTE_OFFSET;
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                 state;
    logic [WB_DEPTH-1:0]    valid;
    logic [AW-1:0]          addr_q [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          count, count_nxt;

    logic [AW-1:0]          push_word, look_word;
    logic                   coal_hit, look_hit_raw, alloc, pop;
    logic [PW-1:0]          coal_idx;
    logic [DATA_LENGTH-1:0] look_data_raw, head_data;
    logic                   unused_low_bits;

    assign push_word       = push_addr[DATA_LENGTH-1:BYTE_OFFSET];
    assign look_word       = lookup_addr[DATA_LENGTH-1:BYTE_OFFSET];
    assign unused_low_bits = ^{push_addr[BYTE_OFFSET-1:0], lookup_addr[BYTE_OFFSET-1:0]};

    // Scan from head (oldest) to youngest so the last match found is the youngest entry.
    always_comb begin
        logic [PW-1:0] idx;
        idx           = '0;
        coal_hit      = 1'b0;
        coal_idx      = '0;
        look_hit_raw  = 1'b0;
        look_data_raw = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && addr_q[idx] == push_word && !(state == REQ && idx == head)) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
            if (valid[idx] && addr_q[idx] == look_word) begin
                look_hit_raw  = 1'b1;
                look_data_raw = data_q[idx];
            end
        end
    end

    assign push_ack    = push_req & ~rst & (coal_hit | ~wb_full_o);
    assign alloc       = push_ack & ~coal_hit;
    assign pop         = (state == REQ) & wb_ack;
    assign count_nxt   = count + CW'(alloc) - CW'(pop);
    assign lookup_hit  = look_hit_raw & ~rst;
    assign lookup_data = rst ? '0 : look_data_raw;
    assign wb_count    = count;

    // A coalesce into the head on the cycle the drain starts must reach memory with the new data.
    assign head_data = (push_ack && coal_hit && coal_idx == head) ? push_data : data_q[head];

    always_ff @(posedge cache_clk) begin
        if (alloc) begin
            addr_q[tail] <= push_word;
            data_q[tail] <= push_data;
        end else if (push_ack) begin
            data_q[coal_idx] <= push_data;
        end
    end

    always_ff @(posedge cache_clk) begin
        if (rst) begin
            valid      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= IDLE;
            wb_req     <= 1'b0;
            wb_data    <= '0;
            wb_empty_o <= 1'b1;
            wb_full_o  <= 1'b0;
        end else begin
            if (pop)   valid[head] <= 1'b0;
            if (alloc) valid[tail] <= 1'b1;
            head       <= head + PW'(pop);
            tail       <= tail + PW'(alloc);
            count      <= count_nxt;
            wb_full_o  <= (count_nxt == CW'(WB_DEPTH));
            wb_empty_o <= (count_nxt == '0);
            case (state)
                IDLE: begin
                    if (!wb_empty_o && !full_flag) begin
                        state   <= REQ;
                        wb_req  <= 1'b1;
                        wb_data <= {head_data, addr_q[head]};
                    end
                end
                REQ: begin
                    if (wb_ack) begin
                        state  <= IDLE;
                        wb_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_renas_write_buffer.sv
// Scoreboard bench for renas_write_buffer: a queue model tracks buffered entries and
// predicts push acceptance, forwarding results and the order/content of drained words.
module tb_renas_write_buffer;
    logic        cache_clk = 0;
    logic        rst = 1, push_req = 0, wb_ack = 0, full_flag = 0;
    logic [31:0] push_addr = 0, push_data = 0, lookup_addr = 0;
    logic        push_ack, wb_full_o, wb_empty_o, lookup_hit, wb_req;
    logic [2:0]  wb_count;
    logic [31:0] lookup_data;
    logic [61:0] wb_data;

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];
    bit   infl = 0;
    int   total = 0, bad = 0;

    renas_write_buffer #(.DATA_LENGTH(32), .BYTE_OFFSET(2), .WB_DEPTH(4)) dut (
        .cache_clk(cache_clk), .rst(rst), .push_req(push_req), .push_addr(push_addr),
        .push_data(push_data), .push_ack(push_ack), .wb_full_o(wb_full_o),
        .wb_empty_o(wb_empty_o), .wb_count(wb_count), .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data), .wb_data(wb_data),
        .wb_req(wb_req), .wb_ack(wb_ack), .full_flag(full_flag)
    );

    always #5 cache_clk = ~cache_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Index of the youngest non-in-flight entry holding this word, or -1.
    function automatic int coal_match(input logic [31:0] a);
        int r = -1;
        for (int i = 0; i < q.size(); i++)
            if (q[i].a[31:2] == a[31:2] && !(infl && i == 0)) r = i;
        return r;
    endfunction

    task automatic model_push(input logic [31:0] a, input logic [31:0] d);
        int m = coal_match(a);
        ent_t e;
        if (m >= 0) q[m].d = d;
        else begin
            e.a = a; e.d = d;
            q.push_back(e);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bit exp_ack;
        @(posedge cache_clk); #1;
        push_req = 1; push_addr = a; push_data = d;
        exp_ack = (coal_match(a) >= 0) || (q.size() < 4);
        @(negedge cache_clk);
        chk("push_ack", push_ack, exp_ack);
        @(posedge cache_clk); #1;
        push_req = 0;
        if (exp_ack) model_push(a, d);
        @(negedge cache_clk);
        chk("count", wb_count, q.size());
        chk("full", wb_full_o, q.size() == 4);
        chk("empty", wb_empty_o, q.size() == 0);
    endtask

    task automatic look(input logic [31:0] a);
        bit          h = 0;
        logic [31:0] d = 0;
        lookup_addr = a;
        #1;
        foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin h = 1; d = q[i].d; end
        chk("lookup_hit", lookup_hit, h);
        if (h) chk("lookup_data", lookup_data, d);
    endtask

    task automatic wait_req();
        int n = 0;
        @(negedge cache_clk);
        while (!wb_req && n < 40) begin
            @(negedge cache_clk);
            n++;
        end
        if (!wb_req) begin
            chk("req_timeout", 0, 1);
            return;
        end
        infl = 1;
        if (q.size() > 0) chk("wb_data", wb_data, {q[0].d, q[0].a[31:2]});
        else chk("req_when_empty", 1, 0);
    endtask

    task automatic ack_req(input int w);
        repeat (w + 1) @(posedge cache_clk);
        #1;
        chk("req_held", wb_req, 1);
        wb_ack = 1;
        @(posedge cache_clk); #1;
        wb_ack = 0;
        if (q.size() > 0) void'(q.pop_front());
        infl = 0;
        @(negedge cache_clk);
        chk("req_fall", wb_req, 0);
        chk("count", wb_count, q.size());
        chk("empty", wb_empty_o, q.size() == 0);
    endtask

    initial begin
        // Reset: outputs quiet, combinational outputs masked during reset.
        push_req = 1; push_addr = 32'h800; lookup_addr = 32'h800;
        @(negedge cache_clk);
        chk("rst_push_ack", push_ack, 0);
        chk("rst_lookup_hit", lookup_hit, 0);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_empty", wb_empty_o, 1);
        chk("rst_full", wb_full_o, 0);
        chk("rst_count", wb_count, 0);
        @(posedge cache_clk); #1;
        rst = 0; push_req = 0;

        // Single push and drain.
        push(32'h0000_0800, 32'hDEAD_BEEF);
        wait_req();
        chk("wb_data_literal", wb_data, {32'hDEAD_BEEF, 30'h200});
        ack_req(0);

        // Fill while memory busy, reject extra, coalesce while full.
        full_flag = 1;
        for (int i = 0; i < 4; i++) push(32'h800 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        repeat (3) @(posedge cache_clk);
        #1;
        chk("req_blocked", wb_req, 0);
        push(32'h810, 32'h5555_5555);
        push(32'h804, 32'h1111_1111);
        look(32'h804);
        look(32'h806);
        look(32'h810);

        // Release and drain in order with delayed acks (pointers wrap).
        @(posedge cache_clk); #1;
        full_flag = 0;
        for (int i = 0; i < 4; i++) begin
            wait_req();
            ack_req(3);
        end

        // In-flight entry is not coalesced.
        push(32'h900, 32'hA);
        wait_req();
        push(32'h900, 32'hB);
        look(32'h900);
        chk("inflight_data", wb_data, {32'hA, 30'h240});
        ack_req(1);
        wait_req();
        ack_req(0);

        // Simultaneous pop and allocate at count=1.
        push(32'h908, 32'hC);
        wait_req();
        @(posedge cache_clk); #1;
        wb_ack = 1; push_req = 1; push_addr = 32'h904; push_data = 32'hD;
        @(negedge cache_clk);
        chk("push_ack_pop", push_ack, (coal_match(32'h904) >= 0) || (q.size() < 4));
        @(posedge cache_clk); #1;
        wb_ack = 0; push_req = 0;
        void'(q.pop_front());
        infl = 0;
        model_push(32'h904, 32'hD);
        @(negedge cache_clk);
        chk("count_pop_push", wb_count, q.size());
        look(32'h908);
        wait_req();
        ack_req(0);

        // Reset mid-drain clears everything.
        full_flag = 1;
        push(32'hA00, 32'h1);
        push(32'hA04, 32'h2);
        push(32'hA08, 32'h3);
        @(posedge cache_clk); #1;
        full_flag = 0;
        wait_req();
        @(posedge cache_clk); #1;
        rst = 1;
        @(posedge cache_clk); #1;
        rst = 0;
        q.delete();
        infl = 0;
        @(negedge cache_clk);
        chk("mid_rst_req", wb_req, 0);
        chk("mid_rst_count", wb_count, 0);
        chk("mid_rst_empty", wb_empty_o, 1);
        look(32'hA00);
        look(32'hA04);
        look(32'hA08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/renas_write_buffer.md
Name: renas_write_buffer

Overview:
- Write buffer between the data cache and main memory. Queues dirty word write-backs from the cache, coalesces repeated writes to the same word, and serves buffered data to cache read lookups.
- Drains one entry at a time into the main memory write-buffer port (wb_data/wb_req/wb_ack/full_flag), all in the cache_clk domain.

Parameters:
- DATA_LENGTH, 32, data/address width (from renas_user_parameters)
- BYTE_OFFSET, 2, byte-offset bits dropped to form the word address
- WB_DEPTH, 4, number of entries (power of two, >=2)

Ports:
- cache_clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_req  in  1  cache requests a word write-back
- push_addr  in  DATA_LENGTH  byte address; bits [BYTE_OFFSET-1:0] ignored
- push_data  in  DATA_LENGTH  write data
- push_ack  out  1  combinational; push accepted this cycle
- wb_full_o  out  1  registered; count == WB_DEPTH
- wb_empty_o  out  1  registered; count == 0
- wb_count  out  $clog2(WB_DEPTH)+1  valid entries
- lookup_addr  in  DATA_LENGTH  cache read address for forwarding
- lookup_hit  out  1  combinational; a valid entry matches the word address
- lookup_data  out  DATA_LENGTH  data of the matching entry
- wb_data  out  2*DATA_LENGTH-BYTE_OFFSET  {data[DATA_LENGTH-1:0], word_addr[DATA_LENGTH-BYTE_OFFSET-1:0]} of the head entry
- wb_req  out  1  drain request to memory
- wb_ack  in  1  memory accepted the entry (one-cycle pulse)
- full_flag  in  1  memory write port busy

Behaviour:
- Reset: synchronous on rst. All entries invalid, pointers 0, count 0. wb_req=0, wb_data=0, wb_empty_o=1, wb_full_o=0, state IDLE. push_ack and lookup_hit are 0 in the reset cycle.
- Entry layout: word_addr = push_addr[DATA_LENGTH-1:BYTE_OFFSET] plus data. The FIFO is circular with head/tail pointers that wrap modulo WB_DEPTH.
- Coalescing:
  - If push_req matches the word address of a valid entry that is not in flight, that entry's data is overwritten and push_ack=1.
  - Pointers and count do not change. This is allowed even when the buffer is full.
- Allocation:
  - Otherwise push_ack = push_req & ~wb_full_o. The entry is written at tail, tail increments and count increments.
  - A push while full with no coalesce match is not accepted (push_ack=0). The cache must hold push_req.
- In-flight rule: the head entry is in flight while state=REQ. It is never coalesced. A matching push allocates a new entry instead.
- Drain FSM:
  - IDLE: if !wb_empty_o && !full_flag, go to REQ next cycle.
  - REQ: wb_req=1 and wb_data is registered from head at entry. Hold until wb_ack=1. On wb_ack, pop the head (head++, count--), deassert wb_req next cycle, return to IDLE.
  - Minimum of 2 cycles between successive requests.
- Simultaneous allocate and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, a push is rejected even if a pop occurs in the same cycle, because full is evaluated on the registered count.
  - When count=1, the in-flight entry is popped while the new entry is allocated, with no corruption.
- Forwarding:
  - lookup_hit = OR of valid entries whose word address equals lookup_addr[DATA_LENGTH-1:BYTE_OFFSET].
  - With multiple matches (possible only via the in-flight rule), return the youngest entry.
  - Same-cycle push data is not forwarded; it is visible from the next cycle.
- wb_ack received while in IDLE is ignored, with no pop.
- Reset mid-drain clears everything. Any entry in flight is lost; memory-side consistency is the system reset's responsibility.

Test Plan:
- Reset, then push 0x0000_0800/0xDEAD_BEEF with full_flag=0 -> push_ack=1, wb_count=1, REQ after 1 cycle, wb_data={0xDEADBEEF, 30'h200}. Pulse wb_ack -> wb_req falls, wb_empty_o=1.
- Hold full_flag=1 and push 4 distinct words 0x800, 0x804, 0x808, 0x80C -> wb_full_o=1, wb_req stays 0. A 5th push to 0x810 -> push_ack=0. A push to 0x804 with 0x1111_1111 -> push_ack=1, count stays 4, lookup 0x804 returns 0x1111_1111.
- Release full_flag while full, ack each request after 3 cycles -> drains in order 0x800, 0x804, 0x808, 0x80C. Pointers wrap to 0; wb_empty_o=1 at the end.
- While REQ is in flight for 0x900/0xA, push 0x900/0xB -> new entry allocated (count=2). lookup 0x900 returns 0xB. The in-flight wb_data keeps data 0xA; after ack, the next request carries 0xB.
- With count=1 and REQ active, assert wb_ack and push 0x904 in the same cycle -> count stays 1, the next request is 0x904.
- Assert rst during REQ with 3 entries -> next cycle wb_req=0, wb_count=0, wb_empty_o=1, lookup_hit=0 for all earlier addresses.
